// File: rtl/edge_freq_meter.sv
// edge_freq_meter: counts edges of an asynchronous square wave over a fixed
// gate window of GATE_CYCLES clk cycles and reports the count with a
// one-cycle valid strobe. The window is started by a start pulse, or
// restarted automatically when cont_en is held high.
//
// Optional build macro: EDGE_FREQ_METER_BOTH_EDGES_EN
//   undefined -> only rising edges of sig_in are counted
//   defined   -> rising and falling edges are both counted (2x result)
module edge_freq_meter #(
  parameter int GATE_CYCLES = 1000,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             start,
  input  logic             cont_en,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic             count_valid,
  output logic             overflow
);

  localparam int GATE_W       = $clog2(GATE_CYCLES);
  localparam int PRIME_CYCLES = SYNC_STAGES + 1;
  localparam int PRIME_W      = $clog2(PRIME_CYCLES + 1);

  localparam logic [GATE_W-1:0]  GATE_LAST  = GATE_W'(GATE_CYCLES - 1);
  localparam logic [PRIME_W-1:0] PRIME_DONE = PRIME_W'(PRIME_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   start_win;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sig_s;
  logic                   sig_s_d;
  logic                   edge_raw;
  logic                   edge_p;
  logic [PRIME_W-1:0]     prime_cnt;
  logic                   primed;

  logic [GATE_W-1:0] gate_cnt;
  logic [CNT_W-1:0]  acc;
  logic              sat;
  logic [CNT_W:0]    sum_ext;
  logic [CNT_W-1:0]  sum_sat;
  logic              add_ovf;
  logic              gate_last;

  assign sig_s  = sync_q[SYNC_STAGES-1];
  assign primed = (prime_cnt == PRIME_DONE);

`ifdef EDGE_FREQ_METER_BOTH_EDGES_EN
  assign edge_raw = sig_s ^ sig_s_d;
`else
  assign edge_raw = sig_s & ~sig_s_d;
`endif

  // Shift the raw input through the synchroniser chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
    end
  end

  // Register the edge pulse, masked until the chain has filled after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_s_d   <= 1'b0;
      edge_p    <= 1'b0;
      prime_cnt <= '0;
    end else begin
      sig_s_d <= sig_s;
      if (!primed) begin
        prime_cnt <= prime_cnt + PRIME_W'(1);
        edge_p    <= 1'b0;
      end else begin
        edge_p <= edge_raw;
      end
    end
  end

  // Saturating add of this cycle's edge onto the running total
  always_comb begin
    sum_ext   = {1'b0, acc} + {{CNT_W{1'b0}}, edge_p};
    add_ovf   = sum_ext[CNT_W];
    sum_sat   = add_ovf ? CNT_MAX : sum_ext[CNT_W-1:0];
    gate_last = (gate_cnt == GATE_LAST);
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start_win marks the cycles that open a fresh window
  always_comb begin
    state_d   = state_q;
    start_win = 1'b0;
    case (state_q)
      IDLE: begin
        if (start || cont_en) begin
          state_d   = MEASURE;
          start_win = 1'b1;
        end
      end
      MEASURE: begin
        if (gate_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (cont_en) begin
          state_d   = MEASURE;
          start_win = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Gate timing, edge accumulation and result latching
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gate_cnt <= '0;
      acc      <= '0;
      sat      <= 1'b0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (start_win) begin
      gate_cnt <= '0;
      acc      <= '0;
      sat      <= 1'b0;
    end else if (state_q == MEASURE) begin
      gate_cnt <= gate_cnt + GATE_W'(1);
      acc      <= sum_sat;
      sat      <= sat | add_ovf;
      if (gate_last) begin
        count    <= sum_sat;
        overflow <= sat | add_ovf;
      end
    end
  end

  assign busy        = (state_q != IDLE);
  assign count_valid = (state_q == DONE);

endmodule

// File: tb/tb_edge_freq_meter.sv
// Directed testbench for edge_freq_meter: a default instance (GATE 1000,
// 16-bit count) and a small instance (GATE 100, 4-bit count) for saturation.
module tb_edge_freq_meter;

`ifdef EDGE_FREQ_METER_BOTH_EDGES_EN
  localparam int EXP_EDGES = 200;
`else
  localparam int EXP_EDGES = 100;
`endif

  logic        clk;
  logic        rst;
  logic        sig_in;
  logic        start;
  logic        cont_en;
  logic        busy;
  logic [15:0] count;
  logic        count_valid;
  logic        overflow;

  logic        sig2;
  logic        start2;
  logic        cont2;
  logic        busy2;
  logic [3:0]  count2;
  logic        count_valid2;
  logic        overflow2;

  int total;
  int bad;
  int pat_mode;
  int pat2;
  int phase;

  edge_freq_meter #(.GATE_CYCLES(1000), .CNT_W(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sig_in(sig_in), .start(start), .cont_en(cont_en),
    .busy(busy), .count(count), .count_valid(count_valid), .overflow(overflow)
  );

  edge_freq_meter #(.GATE_CYCLES(100), .CNT_W(4), .SYNC_STAGES(2)) dut2 (
    .clk(clk), .rst(rst), .sig_in(sig2), .start(start2), .cont_en(cont2),
    .busy(busy2), .count(count2), .count_valid(count_valid2), .overflow(overflow2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Input pattern generators, updated 1 time unit after each rising edge
  initial begin
    sig_in = 1'b0;
    sig2   = 1'b0;
    phase  = 0;
    forever begin
      @(posedge clk);
      #1;
      case (pat_mode)
        0: sig_in = 1'b0;
        1: sig_in = 1'b1;
        default: begin
          sig_in = (phase == 0);
          phase  = (phase == 9) ? 0 : phase + 1;
        end
      endcase
      if (pat2 == 1) sig2 = ~sig2;
      else           sig2 = 1'b0;
    end
  end

  // Hard time limit so the bench always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Wait for the next count_valid strobe, counting cycles from now
  task automatic wait_strobe(input int limit, output int cycles, output bit got);
    cycles = 0;
    got    = 1'b0;
    while (cycles < limit && !got) begin
      @(posedge clk);
      #1;
      cycles++;
      if (count_valid) got = 1'b1;
    end
  endtask

  // Pulse start for one cycle and wait for the strobe, tallying busy cycles
  task automatic run_window(output int lat, output bit got, output int busy_cnt);
    start    = 1'b1;
    lat      = 0;
    got      = 1'b0;
    busy_cnt = 0;
    while (lat < 1100 && !got) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) start = 1'b0;
      if (busy) busy_cnt++;
      if (count_valid) got = 1'b1;
    end
  endtask

  task automatic test_reset;
    int  lat;
    int  bc;
    bit  got;
    $display("[TB] test_reset");
    pat_mode = 1;
    rst      = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    total++; if (count_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b expected 0", count_valid); end
    total++; if (count !== 16'd0) begin bad++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL reset_ovf: got %b expected 0", overflow); end
    rst = 1'b0;
    run_window(lat, got, bc);
    total++; if (!got || lat != 1001) begin bad++; $display("[TB] FAIL prime_latency: got %0d expected 1001", lat); end
    total++; if (count !== 16'd0) begin bad++; $display("[TB] FAIL prime_count: got %0d expected 0", count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL prime_ovf: got %b expected 0", overflow); end
  endtask

  task automatic test_single;
    int lat;
    int bc;
    bit got;
    $display("[TB] test_single");
    pat_mode = 2;
    repeat (30) @(posedge clk);
    #1;
    run_window(lat, got, bc);
    total++; if (!got || lat != 1001) begin bad++; $display("[TB] FAIL single_latency: got %0d expected 1001", lat); end
    total++; if (count !== 16'(EXP_EDGES)) begin bad++; $display("[TB] FAIL single_count: got %0d expected %0d", count, EXP_EDGES); end
    total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL single_ovf: got %b expected 0", overflow); end
    total++; if (bc != 1001) begin bad++; $display("[TB] FAIL single_busy_len: got %0d expected 1001", bc); end
    @(posedge clk);
    #1;
    total++; if (count_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_strobe_len: got %b expected 0", count_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL single_busy_end: got %b expected 0", busy); end
    total++; if (count !== 16'(EXP_EDGES)) begin bad++; $display("[TB] FAIL single_hold: got %0d expected %0d", count, EXP_EDGES); end
  endtask

  task automatic test_continuous;
    int c;
    int busy_seen;
    bit got;
    $display("[TB] test_continuous");
    cont_en = 1'b1;
    wait_strobe(1100, c, got);
    total++; if (!got || c != 1001) begin bad++; $display("[TB] FAIL cont_first: got %0d expected 1001", c); end
    total++; if (count !== 16'(EXP_EDGES)) begin bad++; $display("[TB] FAIL cont_count1: got %0d expected %0d", count, EXP_EDGES); end
    wait_strobe(1100, c, got);
    total++; if (!got || c != 1001) begin bad++; $display("[TB] FAIL cont_spacing2: got %0d expected 1001", c); end
    total++; if (count !== 16'(EXP_EDGES)) begin bad++; $display("[TB] FAIL cont_count2: got %0d expected %0d", count, EXP_EDGES); end
    repeat (300) @(posedge clk);
    #1;
    cont_en = 1'b0;
    wait_strobe(1100, c, got);
    total++; if (!got || c != 701) begin bad++; $display("[TB] FAIL cont_spacing3: got %0d expected 1001", 300 + c); end
    total++; if (count !== 16'(EXP_EDGES)) begin bad++; $display("[TB] FAIL cont_count3: got %0d expected %0d", count, EXP_EDGES); end
    busy_seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (busy || count_valid) busy_seen++;
    end
    total++; if (busy_seen != 0) begin bad++; $display("[TB] FAIL cont_stop: got %0d busy cycles expected 0", busy_seen); end
  endtask

  task automatic test_back_to_back;
    int n;
    int extra;
    bit got;
    $display("[TB] test_back_to_back");
    start = 1'b1;
    n     = 0;
    got   = 1'b0;
    while (n < 1100 && !got) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1)   start = 1'b0;
      if (n == 500) start = 1'b1;
      if (n == 501) start = 1'b0;
      if (count_valid) got = 1'b1;
    end
    total++; if (!got || n != 1001) begin bad++; $display("[TB] FAIL ignore_latency: got %0d expected 1001", n); end
    total++; if (count !== 16'(EXP_EDGES)) begin bad++; $display("[TB] FAIL ignore_count: got %0d expected %0d", count, EXP_EDGES); end
    extra = 0;
    repeat (1100) begin
      @(posedge clk);
      #1;
      if (busy || count_valid) extra++;
    end
    total++; if (extra != 0) begin bad++; $display("[TB] FAIL ignore_no_restart: got %0d busy cycles expected 0", extra); end
  endtask

  task automatic test_reset_mid;
    int n;
    int extra;
    $display("[TB] test_reset_mid");
    start = 1'b1;
    n     = 0;
    while (n < 400) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) start = 1'b0;
    end
    rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_busy: got %b expected 0", busy); end
    total++; if (count_valid !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_valid: got %b expected 0", count_valid); end
    total++; if (count !== 16'd0) begin bad++; $display("[TB] FAIL rstmid_count: got %0d expected 0", count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_ovf: got %b expected 0", overflow); end
    repeat (3) @(posedge clk);
    #1;
    rst   = 1'b0;
    extra = 0;
    repeat (1100) begin
      @(posedge clk);
      #1;
      if (busy || count_valid) extra++;
    end
    total++; if (extra != 0) begin bad++; $display("[TB] FAIL rstmid_no_strobe: got %0d busy cycles expected 0", extra); end
  endtask

  task automatic test_saturate;
    int n;
    bit got;
    $display("[TB] test_saturate");
    pat2 = 1;
    repeat (10) @(posedge clk);
    #1;
    start2 = 1'b1;
    n      = 0;
    got    = 1'b0;
    while (n < 200 && !got) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) start2 = 1'b0;
      if (count_valid2) got = 1'b1;
    end
    total++; if (!got || n != 101) begin bad++; $display("[TB] FAIL sat_latency: got %0d expected 101", n); end
    total++; if (busy2 !== 1'b1) begin bad++; $display("[TB] FAIL sat_busy: got %b expected 1", busy2); end
    total++; if (count2 !== 4'd15) begin bad++; $display("[TB] FAIL sat_count: got %0d expected 15", count2); end
    total++; if (overflow2 !== 1'b1) begin bad++; $display("[TB] FAIL sat_ovf: got %b expected 1", overflow2); end
    pat2 = 0;
    repeat (10) @(posedge clk);
    #1;
    total++; if (count2 !== 4'd15) begin bad++; $display("[TB] FAIL sat_hold: got %0d expected 15", count2); end
    start2 = 1'b1;
    n      = 0;
    got    = 1'b0;
    while (n < 200 && !got) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) start2 = 1'b0;
      if (count_valid2) got = 1'b1;
    end
    total++; if (!got) begin bad++; $display("[TB] FAIL sat_second_strobe: got %0d cycles without strobe expected 101", n); end
    total++; if (count2 !== 4'd0) begin bad++; $display("[TB] FAIL sat_quiet_count: got %0d expected 0", count2); end
    total++; if (overflow2 !== 1'b0) begin bad++; $display("[TB] FAIL sat_quiet_ovf: got %b expected 0", overflow2); end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    pat_mode = 1;
    pat2     = 0;
    rst      = 1'b1;
    start    = 1'b0;
    cont_en  = 1'b0;
    start2   = 1'b0;
    cont2    = 1'b0;
    test_reset();
    test_single();
    test_continuous();
    test_back_to_back();
    test_reset_mid();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
